// File: rtl/alu_pkg.sv
// Shared types and constants for the int_alu_sched block.
// Opcodes, FSM states, width and divide-by-zero result.
package alu_pkg;

  localparam int W = 32;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_MUL  = 5'd2,
    OP_DIV  = 5'd3,
    OP_MOD  = 5'd4,
    OP_EQ   = 5'd5,
    OP_NE   = 5'd6,
    OP_GE   = 5'd7,
    OP_GT   = 5'd8,
    OP_LE   = 5'd9,
    OP_LT   = 5'd10,
    OP_LNOT = 5'd11,
    OP_BNOT = 5'd12,
    OP_SHL  = 5'd13,
    OP_ASHL = 5'd14,
    OP_SHR  = 5'd15,
    OP_ASHR = 5'd16,
    OP_SEL  = 5'd17
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // DIV by zero yields all ones; MOD by zero yields the dividend.
  localparam logic [W-1:0] DIV0_QUOT = '1;

  function automatic logic is_div(input op_t op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/int_alu_sched_if.sv
// Request/result bundle between two requesters and the ALU.
// master = requester side, slave = ALU side.
interface int_alu_sched_if;
  import alu_pkg::*;

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  op_t  [1:0]        req_op;
  logic [1:0][W-1:0] req_a;
  logic [1:0][W-1:0] req_b;
  logic [1:0][W-1:0] req_c;
  logic              res_valid;
  logic              res_ready;
  logic [W-1:0]      res_data;
  logic              res_id;
  logic              res_err;

  modport master (
    output req_valid, req_op, req_a, req_b, req_c,
    output res_ready,
    input  req_ready, res_valid, res_data, res_id, res_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_c,
    input  res_ready,
    output req_ready, res_valid, res_data, res_id, res_err
  );

endinterface

// File: rtl/alu_divider.sv
// Iterative signed divider: 32 restoring steps on magnitudes.
// First step happens on the start edge; sign fix-up is on the outputs.
module alu_divider
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_quot,
  output logic [W-1:0] o_rem,
  output logic         o_div_zero
);

  logic         r_busy;
  logic [5:0]   r_cnt;
  logic [W-1:0] r_q;
  logic [W-1:0] r_r;
  logic [W-1:0] r_d;
  logic [W-1:0] r_a;
  logic         r_negq;
  logic         r_negr;
  logic         r_zero;

  logic [W-1:0]   w_abs_a;
  logic [W-1:0]   w_abs_b;
  logic [2*W-1:0] w_first;
  logic [2*W-1:0] w_next;

  // One restoring step: returns {remainder, quotient}.
  function automatic logic [2*W-1:0] div_step(
    input logic [W-1:0] r,
    input logic [W-1:0] q,
    input logic [W-1:0] d
  );
    logic [W:0] sh;
    logic [W:0] diff;
    sh   = {r, q[W-1]};
    diff = sh - {1'b0, d};
    if (diff[W])
      return {sh[W-1:0], q[W-2:0], 1'b0};
    else
      return {diff[W-1:0], q[W-2:0], 1'b1};
  endfunction

  assign w_abs_a = i_a[W-1] ? (~i_a + 1'b1) : i_a;
  assign w_abs_b = i_b[W-1] ? (~i_b + 1'b1) : i_b;
  assign w_first = div_step('0, w_abs_a, w_abs_b);
  assign w_next  = div_step(r_r, r_q, r_d);

  // Load plus first step on start, then 31 more steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_d    <= '0;
      r_a    <= '0;
      r_negq <= 1'b0;
      r_negr <= 1'b0;
      r_zero <= 1'b0;
    end else if (i_start) begin
      r_busy     <= 1'b1;
      r_cnt      <= 6'd1;
      {r_r, r_q} <= w_first;
      r_d        <= w_abs_b;
      r_a        <= i_a;
      r_negq     <= i_a[W-1] ^ i_b[W-1];
      r_negr     <= i_a[W-1];
      r_zero     <= (i_b == '0);
    end else if (r_busy) begin
      if (r_cnt == 6'd32) begin
        r_busy <= 1'b0;
      end else begin
        {r_r, r_q} <= w_next;
        r_cnt      <= r_cnt + 6'd1;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_busy && (r_cnt == 6'd32);
  assign o_div_zero = r_zero;
  assign o_quot = r_zero ? DIV0_QUOT :
                  r_negq ? (~r_q + 1'b1) : r_q;
  assign o_rem  = r_zero ? r_a :
                  r_negr ? (~r_r + 1'b1) : r_r;

endmodule

// File: rtl/int_alu_sched.sv
// Two-port round-robin front end around one shared 32-bit ALU.
// Single-cycle ops finish on the accept edge; DIV/MOD use alu_divider.
module int_alu_sched
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  int_alu_sched_if.slave  bus
);

  state_t       r_state;
  logic         r_ptr;
  logic         r_id;
  logic         r_err;
  logic         r_is_div;
  logic [W-1:0] r_data;

  logic [1:0]   w_gnt;
  logic         w_sel;
  logic         w_fire;
  op_t          w_op;
  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic [W-1:0] w_c;
  logic         w_big;
  logic [W-1:0] w_asr;
  logic [W-1:0] w_alu;
  logic         w_div_start;
  logic         w_div_busy;
  logic         w_div_done;
  logic         w_div_zero;
  logic [W-1:0] w_quot;
  logic [W-1:0] w_rem;

  // Grant: single valid wins, ties go to the pointer.
  always_comb begin
    w_gnt = 2'b00;
    if (r_state == S_IDLE && !rst) begin
      case (bus.req_valid)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_ptr ? 2'b10 : 2'b01;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  assign w_sel  = w_gnt[1];
  assign w_fire = |w_gnt;
  assign w_op   = bus.req_op[w_sel];
  assign w_a    = bus.req_a[w_sel];
  assign w_b    = bus.req_b[w_sel];
  assign w_c    = bus.req_c[w_sel];
  assign w_big  = |w_b[W-1:5];
  assign w_asr  = $signed(w_a) >>> w_b[4:0];

  // Single-cycle op mux.
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = w_a + w_b;
      OP_SUB:  w_alu = w_a - w_b;
      OP_MUL:  w_alu = w_a * w_b;
      OP_EQ:   w_alu[0] = (w_a == w_b);
      OP_NE:   w_alu[0] = (w_a != w_b);
      OP_GE:   w_alu[0] = ($signed(w_a) >= $signed(w_b));
      OP_GT:   w_alu[0] = ($signed(w_a) >  $signed(w_b));
      OP_LE:   w_alu[0] = ($signed(w_a) <= $signed(w_b));
      OP_LT:   w_alu[0] = ($signed(w_a) <  $signed(w_b));
      OP_LNOT: w_alu[0] = (w_a == '0);
      OP_BNOT: w_alu = ~w_a;
      OP_SHL,
      OP_ASHL: w_alu = w_big ? '0 : (w_a << w_b[4:0]);
      OP_SHR:  w_alu = w_big ? '0 : (w_a >> w_b[4:0]);
      OP_ASHR: w_alu = w_big ? {W{w_a[W-1]}} : w_asr;
      OP_SEL:  w_alu = (w_a != '0) ? w_b : w_c;
      default: w_alu = '0;
    endcase
  end

  assign w_div_start = w_fire && is_div(w_op);

  alu_divider u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_a        (w_a),
    .i_b        (w_b),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quot     (w_quot),
    .o_rem      (w_rem),
    .o_div_zero (w_div_zero)
  );

  // Control FSM, round-robin pointer and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= 1'b0;
      r_id     <= 1'b0;
      r_err    <= 1'b0;
      r_is_div <= 1'b0;
      r_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_fire) begin
          r_ptr    <= ~w_sel;
          r_id     <= w_sel;
          r_is_div <= (w_op == OP_DIV);
          if (is_div(w_op)) begin
            r_state <= S_DIV;
          end else begin
            r_data  <= w_alu;
            r_err   <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DIV: if (w_div_done) begin
          r_data  <= r_is_div ? w_quot : w_rem;
          r_err   <= w_div_zero;
          r_state <= S_DONE;
        end else if (!w_div_busy) begin
          r_state <= S_IDLE;
        end
        S_DONE: if (bus.res_ready) begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_gnt;
  assign bus.res_valid = (r_state == S_DONE);
  assign bus.res_data  = r_data;
  assign bus.res_id    = r_id;
  assign bus.res_err   = r_err;

endmodule

// File: tb/tb_int_alu_sched.sv
// Self-checking bench for int_alu_sched.
// Random and directed ops against a plain-arithmetic reference.
module tb_int_alu_sched;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  int_alu_sched_if bus();

  int_alu_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void ref_alu(
    input  op_t         op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    output logic [31:0] y,
    output logic        e
  );
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    e  = 1'b0;
    y  = 32'd0;
    case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_MUL: y = a * b;
      OP_DIV:
        if (b == 0) begin y = 32'hFFFFFFFF; e = 1'b1; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) y = a;
        else y = sa / sb;
      OP_MOD:
        if (b == 0) begin y = a; e = 1'b1; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) y = 32'd0;
        else y = sa % sb;
      OP_EQ:   y = (a == b) ? 32'd1 : 32'd0;
      OP_NE:   y = (a != b) ? 32'd1 : 32'd0;
      OP_GE:   y = (sa >= sb) ? 32'd1 : 32'd0;
      OP_GT:   y = (sa > sb) ? 32'd1 : 32'd0;
      OP_LE:   y = (sa <= sb) ? 32'd1 : 32'd0;
      OP_LT:   y = (sa < sb) ? 32'd1 : 32'd0;
      OP_LNOT: y = (a == 0) ? 32'd1 : 32'd0;
      OP_BNOT: y = ~a;
      OP_SHL, OP_ASHL:
        if (b >= 32) y = 32'd0;
        else y = a << b;
      OP_SHR:
        if (b >= 32) y = 32'd0;
        else y = a >> b;
      OP_ASHR:
        if (b >= 32) y = (sa < 0) ? 32'hFFFFFFFF : 32'd0;
        else y = sa >>> b;
      OP_SEL:  y = (a != 0) ? b : c;
      default: y = 32'd0;
    endcase
  endfunction

  task automatic do_op(
    input  int          id,
    input  op_t         op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    output logic [31:0] d,
    output logic        rid,
    output logic        e,
    output int          lat,
    output bit          ok
  );
    int n;
    @(negedge clk);
    bus.req_op[id] = op;
    bus.req_a[id]  = a;
    bus.req_b[id]  = b;
    bus.req_c[id]  = c;
    bus.req_valid[id] = 1'b1;
    #1;
    n = 0;
    while (!bus.req_ready[id] && n < 50) begin
      @(negedge clk); #1; n++;
    end
    ok = bus.req_ready[id];
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (!bus.res_valid && lat < 60);
    d   = bus.res_data;
    rid = bus.res_id;
    e   = bus.res_err;
  endtask

  task automatic test_reset();
    #12;
    bus.req_valid = 2'b11;
    #1;
    total++;
    if ({bus.req_ready, bus.res_valid, bus.res_data,
         bus.res_id, bus.res_err} !== 36'd0) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b v=%b d=%h id=%b e=%b want all 0",
               bus.req_ready, bus.res_valid, bus.res_data,
               bus.res_id, bus.res_err);
    end
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({bus.req_ready, bus.res_valid} !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_reset got rdy=%b v=%b want 00/0",
               bus.req_ready, bus.res_valid);
    end
  endtask

  task automatic test_basic();
    op_t         ops [8] = '{OP_ADD, OP_SUB, OP_MUL, OP_BNOT,
                             OP_SHL, OP_SHR, OP_GT, OP_EQ};
    logic [31:0] exp [8] = '{32'd61, 32'd23, 32'd798, 32'd4294967253,
                             32'd22020096, 32'd0, 32'd1, 32'd0};
    logic [31:0] d;
    logic        rid, e;
    int          lat;
    bit          ok;
    for (int i = 0; i < 8; i++) begin
      do_op(0, ops[i], 32'd42, 32'd19, 32'd0, d, rid, e, lat, ok);
      total++;
      if (d !== exp[i]) begin
        bad++;
        $display("FAIL basic_%s data got=%0d want=%0d",
                 ops[i].name(), d, exp[i]);
      end
      total++;
      if (!ok || rid !== 1'b0 || e !== 1'b0 || lat != 1) begin
        bad++;
        $display("FAIL basic_%s meta got ok=%0d id=%b err=%b lat=%0d want 1/0/0/1",
                 ops[i].name(), ok, rid, e, lat);
      end
    end
  endtask

  task automatic test_div();
    op_t         ops [8] = '{OP_DIV, OP_MOD, OP_DIV, OP_MOD,
                             OP_DIV, OP_MOD, OP_DIV, OP_MOD};
    logic [31:0] as [8] = '{32'd42, 32'd42, 32'hFFFFFFF9, 32'hFFFFFFF9,
                            32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] bs [8] = '{32'd19, 32'd19, 32'd2, 32'd2,
                            32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [8] = '{32'd2, 32'd4, 32'hFFFFFFFD, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    logic        xer [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
    logic [31:0] d;
    logic        rid, e;
    int          lat;
    bit          ok;
    for (int i = 0; i < 8; i++) begin
      do_op(i % 2, ops[i], as[i], bs[i], 32'd0, d, rid, e, lat, ok);
      total++;
      if (d !== exp[i] || e !== xer[i]) begin
        bad++;
        $display("FAIL div_%0d result got d=%h err=%b want d=%h err=%b",
                 i, d, e, exp[i], xer[i]);
      end
      total++;
      if (!ok || lat != 33 || rid !== 1'(i % 2)) begin
        bad++;
        $display("FAIL div_%0d meta got ok=%0d lat=%0d id=%b want 1/33/%0d",
                 i, ok, lat, rid, i % 2);
      end
    end
  endtask

  task automatic test_arb();
    logic [31:0] exp [2];
    logic        e;
    int          n;
    rst = 1'b1;
    bus.req_op[0] = OP_ADD;
    bus.req_a[0]  = 32'd1;
    bus.req_b[0]  = 32'd2;
    bus.req_op[1] = OP_SUB;
    bus.req_a[1]  = 32'd10;
    bus.req_b[1]  = 32'd3;
    ref_alu(OP_ADD, 32'd1, 32'd2, 32'd0, exp[0], e);
    ref_alu(OP_SUB, 32'd10, 32'd3, 32'd0, exp[1], e);
    bus.req_valid = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (bus.req_ready == 2'b00 && n < 20) begin
        @(negedge clk); #1; n++;
      end
      total++;
      if (bus.req_ready !== 2'(1 << (k % 2))) begin
        bad++;
        $display("FAIL arb_grant_%0d got rdy=%b want %b",
                 k, bus.req_ready, 2'(1 << (k % 2)));
      end
      @(negedge clk); #1;
      total++;
      if (!bus.res_valid || bus.res_id !== 1'(k % 2) ||
          bus.res_data !== exp[k % 2] || bus.req_ready !== 2'b00) begin
        bad++;
        $display("FAIL arb_result_%0d got v=%b id=%b d=%0d rdy=%b want 1/%0d/%0d/00",
                 k, bus.res_valid, bus.res_id, bus.res_data,
                 bus.req_ready, k % 2, exp[k % 2]);
      end
      @(negedge clk); #1;
    end
    bus.req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic        rid, e;
    int          lat;
    bit          ok;
    bus.res_ready = 1'b0;
    do_op(0, OP_SEL, 32'd0, 32'd42, 32'd9001, d, rid, e, lat, ok);
    total++;
    if (d !== 32'd9001 || lat != 1) begin
      bad++;
      $display("FAIL bp_sel got d=%0d lat=%0d want 9001/1", d, lat);
    end
    bus.req_op[1] = OP_ADD;
    bus.req_a[1]  = 32'd3;
    bus.req_b[1]  = 32'd4;
    bus.req_valid[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      total++;
      if (!bus.res_valid || bus.res_data !== 32'd9001 ||
          bus.res_id !== 1'b0 || bus.req_ready !== 2'b00) begin
        bad++;
        $display("FAIL bp_hold_%0d got v=%b d=%0d id=%b rdy=%b want 1/9001/0/00",
                 k, bus.res_valid, bus.res_data, bus.res_id, bus.req_ready);
      end
    end
    bus.res_ready = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 2'b00) begin
      bad++;
      $display("FAIL bp_handshake_cycle got rdy=%b want 00", bus.req_ready);
    end
    @(negedge clk); #1;
    total++;
    if (bus.req_ready !== 2'b10 || bus.res_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_next_grant got rdy=%b v=%b want 10/0",
               bus.req_ready, bus.res_valid);
    end
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    @(negedge clk); #1;
    total++;
    if (!bus.res_valid || bus.res_data !== 32'd7 || bus.res_id !== 1'b1) begin
      bad++;
      $display("FAIL bp_after got v=%b d=%0d id=%b want 1/7/1",
               bus.res_valid, bus.res_data, bus.res_id);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        rid, e;
    int          lat, n;
    bit          ok;
    int          seen;
    @(negedge clk);
    bus.req_op[1] = OP_DIV;
    bus.req_a[1]  = 32'd1000;
    bus.req_b[1]  = 32'd7;
    bus.req_valid[1] = 1'b1;
    #1;
    n = 0;
    while (!bus.req_ready[1] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    total++;
    if (bus.res_id !== 1'b1 || bus.res_valid !== 1'b0) begin
      bad++;
      $display("FAIL rmid_before got id=%b v=%b want 1/0",
               bus.res_id, bus.res_valid);
    end
    rst = 1'b1;
    bus.req_valid[0] = 1'b1;
    #1;
    total++;
    if ({bus.req_ready, bus.res_valid, bus.res_data,
         bus.res_id, bus.res_err} !== 36'd0) begin
      bad++;
      $display("FAIL rmid_outputs got rdy=%b v=%b d=%h id=%b e=%b want all 0",
               bus.req_ready, bus.res_valid, bus.res_data,
               bus.res_id, bus.res_err);
    end
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL rmid_discard got %0d valid cycles want 0", seen);
    end
    do_op(0, OP_ADD, 32'd100, 32'd23, 32'd0, d, rid, e, lat, ok);
    total++;
    if (!ok || d !== 32'd123 || rid !== 1'b0 || lat != 1) begin
      bad++;
      $display("FAIL rmid_add got ok=%0d d=%0d id=%b lat=%0d want 1/123/0/1",
               ok, d, rid, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, c, d, y;
    logic        rid, e, ye;
    int          lat, id, xl;
    bit          ok;
    op_t         op;
    for (int i = 0; i < 60; i++) begin
      op = op_t'($urandom_range(0, 17));
      a  = $urandom;
      c  = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(0, 40);
        2: b = 32'd0;
        default: b = 32'd0 - $urandom_range(1, 5);
      endcase
      if ($urandom_range(0, 4) == 0) a = 32'd0;
      if ($urandom_range(0, 9) == 0) a = 32'h80000000;
      id = $urandom_range(0, 1);
      ref_alu(op, a, b, c, y, ye);
      xl = is_div(op) ? 33 : 1;
      do_op(id, op, a, b, c, d, rid, e, lat, ok);
      total++;
      if (d !== y || e !== ye || rid !== 1'(id) || lat != xl || !ok) begin
        bad++;
        $display("FAIL rand_%0d %s a=%h b=%h c=%h got d=%h e=%b id=%b lat=%0d want d=%h e=%b id=%0d lat=%0d",
                 i, op.name(), a, b, c, d, e, rid, lat, y, ye, id, xl);
      end
    end
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.req_op[i] = OP_ADD;
      bus.req_a[i]  = 32'd0;
      bus.req_b[i]  = 32'd0;
      bus.req_c[i]  = 32'd0;
    end
    test_reset();
    test_basic();
    test_div();
    test_arb();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
